// File: rtl/mem_pkg.sv
// Shared constants and bundles for the MEM stage.
// FSM encoding, result-select encoding and the MEM/WB bundle.
package mem_pkg;

  localparam int unsigned DEFAULT_MAX_WAIT = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic RES_ALU = 1'b0;
  localparam logic RES_MEM = 1'b1;

  localparam logic [31:0] ERR_LOAD_DATA = 32'h0;

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } mem_wb_t;

endpackage

// File: rtl/memory_cycle_mem_wb_reg.sv
// MEM/WB pipeline register; a stall inserts a bubble.
// Load data is only replaced when the MEM stage says so.
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        kill,
  input  logic        rdata_upd,
  input  logic [31:0] rdata_val,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [4:0]  RDM,
  input  logic [31:0] PCPlus4M,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RDW,
  output logic [31:0] PCPlus4W
);

  mem_wb_t wb_q, wb_d;

  always_comb begin
    wb_d = wb_q;
    if (stall) begin
      wb_d.reg_write = 1'b0;
    end else begin
      wb_d.reg_write  = RegWriteM & ~kill;
      wb_d.result_src = ResultSrcM;
      wb_d.alu_result = ALUResultM;
      wb_d.rd         = RDM;
      wb_d.pc_plus4   = PCPlus4M;
      if (rdata_upd) wb_d.read_data = rdata_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  end

  assign RegWriteW  = wb_q.reg_write;
  assign ResultSrcW = wb_q.result_src;
  assign ALUResultW = wb_q.alu_result;
  assign ReadDataW  = wb_q.read_data;
  assign RDW        = wb_q.rd;
  assign PCPlus4W   = wb_q.pc_plus4;

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: data-memory handshake, stall and timeout control.
// Feeds the MEM/WB register used by writeback and forwarding.
module memory_cycle
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RDM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        MemErrM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RDW,
  output logic [31:0] PCPlus4W
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;

  logic access, misaligned, is_load;
  logic done, timeout, kill;
  logic rdata_upd;
  logic [31:0] rdata_val;

  always_comb begin
    access     = MemWriteM | (ResultSrcM == RES_MEM);
    misaligned = access & (ALUResultM[1:0] != 2'b00);
    is_load    = (ResultSrcM == RES_MEM) & ~MemWriteM;
    cnt_inc    = cnt_q + 1'b1;
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    StallM     = 1'b0;
    MemErrM    = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    kill       = 1'b0;
    // Outputs stay quiet while reset is held, whatever EX/MEM shows.
    if (rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (misaligned) begin
            MemErrM = 1'b1;
            kill    = 1'b1;
          end else if (access) begin
            dmem_req   = 1'b1;
            dmem_we    = MemWriteM;
            dmem_addr  = ALUResultM;
            dmem_wdata = WriteDataM;
            if (dmem_ready) begin
              done = 1'b1;
            end else begin
              StallM  = 1'b1;
              addr_d  = ALUResultM;
              wdata_d = WriteDataM;
              we_d    = MemWriteM;
              cnt_d   = '0;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          dmem_req   = 1'b1;
          dmem_we    = we_q;
          dmem_addr  = addr_q;
          dmem_wdata = wdata_q;
          cnt_d      = cnt_inc;
          // The issue cycle counts, so req is up MAX_WAIT cycles in total.
          if (dmem_ready) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_inc == CNT_W'(MAX_WAIT - 1)) begin
            timeout = 1'b1;
            MemErrM = 1'b1;
            state_d = ST_IDLE;
          end else begin
            StallM = 1'b1;
          end
        end
        ST_DRAIN: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    rdata_upd = (done & is_load) | timeout | kill;
    rdata_val = (done & is_load) ? dmem_rdata : ERR_LOAD_DATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  mem_wb_reg u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .stall      (StallM),
    .kill       (kill),
    .rdata_upd  (rdata_upd),
    .rdata_val  (rdata_val),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .ALUResultM (ALUResultM),
    .RDM        (RDM),
    .PCPlus4M   (PCPlus4M),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RDW        (RDW),
    .PCPlus4W   (PCPlus4W)
  );

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle with an instruction-level model.
// Built with MAX_WAIT = 4 so the timeout is reachable quickly.
module tb_memory_cycle;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, ResultSrcM = 1'b0, MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, PCPlus4M = '0;
  logic [4:0]  RDM = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        StallM, MemErrM;
  logic        RegWriteW, ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RDW;

  memory_cycle #(.MAX_WAIT(MW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RDM(RDM), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .MemErrM(MemErrM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .RDW(RDW), .PCPlus4W(PCPlus4W)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stall_cnt;
  int req_cnt;

  logic        e_regw = 1'b0, e_rsrc = 1'b0;
  logic [31:0] e_alu = '0, e_rdata = '0, e_pc = '0;
  logic [4:0]  e_rd = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_w();
    chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, e_regw});
    chk("ResultSrcW", {31'd0, ResultSrcW}, {31'd0, e_rsrc});
    chk("ALUResultW", ALUResultW, e_alu);
    chk("ReadDataW", ReadDataW, e_rdata);
    chk("RDW", {27'd0, RDW}, {27'd0, e_rd});
    chk("PCPlus4W", PCPlus4W, e_pc);
  endtask

  // lat = cycles of ready low before it rises; -1 = never answers.
  task automatic run(input logic rw, input logic rs, input logic mw,
                     input logic [31:0] alu, input logic [31:0] wd,
                     input logic [4:0] rd, input logic [31:0] pc,
                     input int lat, input logic [31:0] rdata);
    bit acc, mis, rdy, tmo, stl;
    int k;
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; RDM = rd; PCPlus4M = pc;
    acc = rs | mw;
    mis = acc && (alu[1:0] != 2'b00);
    stall_cnt = 0;
    req_cnt = 0;
    k = 0;
    forever begin
      rdy = (lat >= 0) && (k >= lat);
      dmem_ready = rdy;
      dmem_rdata = rdy ? rdata : (32'hDEAD_0000 + k);
      @(negedge clk);
      tmo = acc && !mis && !rdy && (k == MW - 1);
      stl = acc && !mis && !rdy && !tmo;
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, acc && !mis});
      if (acc && !mis) begin
        chk("dmem_addr", dmem_addr, alu);
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, mw});
        chk("dmem_wdata", dmem_wdata, wd);
      end
      chk("StallM", {31'd0, StallM}, {31'd0, stl});
      chk("MemErrM", {31'd0, MemErrM}, {31'd0, mis || tmo});
      if (StallM) stall_cnt++;
      if (dmem_req) req_cnt++;
      @(posedge clk);
      #1;
      if (stl) begin
        e_regw = 1'b0;
      end else begin
        e_regw = rw && !mis;
        e_rsrc = rs;
        e_alu = alu;
        e_rd = rd;
        e_pc = pc;
        if (mis || tmo) e_rdata = 32'h0;
        else if (acc && rs && !mw) e_rdata = rdata;
      end
      check_w();
      if (!stl) break;
      k++;
      if (k > 40) begin
        chk("stall_bound", 32'd1, 32'd0);
        break;
      end
    end
    dmem_ready = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_err", {31'd0, MemErrM}, 32'd0);
    check_w();
    rst = 1'b1;

    run(1, 1, 0, 32'h100, 32'h0, 5'd7, 32'h1004, 0, 32'hCAFEF00D);
    chk("ld0_stalls", stall_cnt, 32'd0);
    chk("ld0_data", ReadDataW, 32'hCAFEF00D);
    chk("ld0_rd", {27'd0, RDW}, 32'd7);

    run(0, 0, 1, 32'h204, 32'h12345678, 5'd0, 32'h1008, 3, 32'hBAD0BAD0);
    chk("st_stalls", stall_cnt, 32'd3);
    chk("st_rdata_hold", ReadDataW, 32'hCAFEF00D);

    run(1, 0, 0, 32'hABC, 32'h0, 5'd4, 32'h100C, 0, 32'h0);
    run(1, 1, 0, 32'h10, 32'h0, 5'd5, 32'h1010, 0, 32'h11111111);
    chk("b2b_first", ReadDataW, 32'h11111111);
    run(1, 1, 0, 32'h14, 32'h0, 5'd6, 32'h1014, 0, 32'h22222222);
    chk("b2b_second", ReadDataW, 32'h22222222);

    run(1, 1, 0, 32'h102, 32'h0, 5'd3, 32'h1018, 0, 32'h33333333);
    chk("mis_regw", {31'd0, RegWriteW}, 32'd0);
    chk("mis_data", ReadDataW, 32'h0);

    run(1, 1, 0, 32'h40, 32'h0, 5'd8, 32'h101C, 1, 32'h55AA55AA);
    chk("ld1_data", ReadDataW, 32'h55AA55AA);

    run(1, 1, 0, 32'h300, 32'h0, 5'd9, 32'h1020, -1, 32'h0);
    chk("tmo_stalls", stall_cnt, 32'd3);
    chk("tmo_reqs", req_cnt, 32'd4);
    chk("tmo_data", ReadDataW, 32'h0);

    run(1, 0, 0, 32'h77, 32'h0, 5'd10, 32'h1024, 0, 32'h0);
    chk("alu_val", ALUResultW, 32'h77);

    // Reset asserted during the second WAIT cycle of a hung load.
    RegWriteM = 1; ResultSrcM = 1; MemWriteM = 0;
    ALUResultM = 32'h500; RDM = 5'd11; PCPlus4M = 32'h1028;
    dmem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_stall", {31'd0, StallM}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, StallM}, 32'd0);
    chk("rst_mid_err", {31'd0, MemErrM}, 32'd0);
    e_regw = 0; e_rsrc = 0; e_alu = 0; e_rdata = 0; e_rd = 0; e_pc = 0;
    check_w();
    @(negedge clk);
    rst = 1'b1;

    run(1, 0, 0, 32'h99, 32'h0, 5'd12, 32'h2000, 0, 32'h0);
    chk("post_rst_alu", ALUResultW, 32'h99);
    chk("post_rst_regw", {31'd0, RegWriteW}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
